// File: rtl/cpu_cond_pkg.sv
// ---------------------------------------------------------------------------
// cpu_cond_pkg
// Shared types for the conditional-branch resolution logic.
//   cond_e      : 3-bit branch condition codes
//   flags_t     : latched comparator flags {less, greater, equal}
//   FLAGS_RESET : flag value after reset (equal)
//   state_e     : branch unit control states
//   flags_onehot: true when exactly one comparator flag is set
// ---------------------------------------------------------------------------
package cpu_cond_pkg;

  typedef enum logic [2:0] {
    COND_NEVER  = 3'b000,
    COND_EQ     = 3'b001,
    COND_NE     = 3'b010,
    COND_LT     = 3'b011,
    COND_GE     = 3'b100,
    COND_GT     = 3'b101,
    COND_LE     = 3'b110,
    COND_ALWAYS = 3'b111
  } cond_e;

  typedef struct packed {
    logic less;
    logic greater;
    logic equal;
  } flags_t;

  localparam flags_t FLAGS_RESET = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic logic flags_onehot(input flags_t f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

endpackage

// File: rtl/cond_branch_unit_if.sv
// ---------------------------------------------------------------------------
// cond_branch_unit_if
// Bundles the comparator flag inputs, the branch request handshake, the
// result handshake and the status outputs of cond_branch_unit.
//   master : the environment (comparator, issue logic, fetch stage)
//   slave  : the branch unit itself
// ---------------------------------------------------------------------------
interface cond_branch_unit_if #(
  parameter int ADDR_W = 16
);
  // comparator flags
  logic              flag_we;
  logic              a_less;
  logic              a_greater;
  logic              equal;
  // branch request
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_target;
  // branch result
  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic [ADDR_W-1:0] res_next_pc;
  // status
  logic [2:0]        flags_q;
  logic              flag_err;

  modport master (
    output flag_we, a_less, a_greater, equal,
    output br_valid, br_cond, br_pc, br_target,
    output res_ready,
    input  br_ready, res_valid, res_taken, res_next_pc, flags_q, flag_err
  );

  modport slave (
    input  flag_we, a_less, a_greater, equal,
    input  br_valid, br_cond, br_pc, br_target,
    input  res_ready,
    output br_ready, res_valid, res_taken, res_next_pc, flags_q, flag_err
  );

endinterface

// File: rtl/cond_branch_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational branch condition evaluator.
//   flags : comparator flags {less, greater, equal}
//   cond  : condition code
//   taken : 1 when the condition holds for the given flags
// Flags are used bitwise as given, so a non-one-hot value is not repaired
// (e.g. all-zero flags make EQ/LT/GT false and NE true).
// ---------------------------------------------------------------------------
module cond_eval
  import cpu_cond_pkg::*;
(
  input  flags_t flags,
  input  cond_e  cond,
  output logic   taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NEVER:  taken = 1'b0;
      COND_EQ:     taken = flags.equal;
      COND_NE:     taken = ~flags.equal;
      COND_LT:     taken = flags.less;
      COND_GE:     taken = flags.greater | flags.equal;
      COND_GT:     taken = flags.greater;
      COND_LE:     taken = flags.less | flags.equal;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// ---------------------------------------------------------------------------
// cond_branch_unit
// Latches comparator flags on command and resolves branch requests against
// them, returning taken/not-taken and the next PC.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : cond_branch_unit_if slave port
//         flag_we/a_less/a_greater/equal -> flag register
//         br_valid/br_ready/br_cond/br_pc/br_target -> request handshake
//         res_valid/res_ready/res_taken/res_next_pc -> result handshake
//         flags_q, flag_err -> status
// One branch at a time: IDLE accepts, EVAL resolves (stalling while a flag
// write is in flight), HOLD presents the result until it is consumed.
// ---------------------------------------------------------------------------
module cond_branch_unit
  import cpu_cond_pkg::*;
#(
  parameter int ADDR_W = 16   // must match the interface instance
) (
  input logic              clk,
  input logic              rst,
  cond_branch_unit_if.slave bus
);

  state_e            state_reg, state_next;
  flags_t            flags_reg;
  logic              flag_err_reg;
  cond_e             cond_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] target_reg;
  logic              taken_reg;
  logic [ADDR_W-1:0] next_pc_reg;

  flags_t flags_in;
  logic   accept;
  logic   eval_done;
  logic   taken;

  assign flags_in = {bus.a_less, bus.a_greater, bus.equal};

  cond_eval u_cond_eval (
    .flags (flags_reg),
    .cond  (cond_reg),
    .taken (taken)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.br_valid)  state_next = EVAL;
      // A flag write this cycle lands at the edge, so evaluation waits
      // one cycle to see it.
      EVAL:    if (!bus.flag_we)  state_next = HOLD;
      HOLD:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    bus.br_ready  = 1'b0;
    bus.res_valid = 1'b0;
    accept        = 1'b0;
    eval_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        // rst gates ready so nothing is offered while reset is asserted
        bus.br_ready = ~rst;
        accept       = bus.br_valid & ~rst;
      end
      EVAL:    eval_done     = ~bus.flag_we;
      HOLD:    bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- flag register ----------------
  // Independent of the FSM; a flag write in the accept cycle is therefore
  // already visible when the branch reaches EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_reg    <= FLAGS_RESET;
      flag_err_reg <= 1'b0;
    end else if (bus.flag_we) begin
      flags_reg <= flags_in;
      if (!flags_onehot(flags_in)) begin
        flag_err_reg <= 1'b1;
      end
    end
  end

  // ---------------- request capture ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_reg   <= COND_NEVER;
      pc_reg     <= '0;
      target_reg <= '0;
    end else if (accept) begin
      cond_reg   <= cond_e'(bus.br_cond);
      pc_reg     <= bus.br_pc;
      target_reg <= bus.br_target;
    end
  end

  // ---------------- result registers ----------------
  // Loaded only on the resolving EVAL cycle, so they stay stable in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_reg   <= 1'b0;
      next_pc_reg <= '0;
    end else if (eval_done) begin
      taken_reg   <= taken;
      next_pc_reg <= taken ? target_reg : pc_reg + ADDR_W'(1);
    end
  end

  assign bus.res_taken   = taken_reg;
  assign bus.res_next_pc = next_pc_reg;
  assign bus.flags_q     = flags_reg;
  assign bus.flag_err    = flag_err_reg;

endmodule

// File: tb/tb_cond_branch_unit.sv
module tb_cond_branch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cond_branch_unit_if #(.ADDR_W(16)) bus ();

  cond_branch_unit #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference state: last written flags and sticky error
  logic [2:0] m_flags;
  logic       m_err;

  typedef struct {
    bit          wr;
    logic [2:0]  wf;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [15:0] tgt;
    int          hold;
    logic        exp_t;
    logic [15:0] exp_nx;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Condition as "any of the selected flags set", optionally inverted.
  function automatic logic model_taken(input logic [2:0] f, input logic [2:0] c);
    logic [2:0] mask;
    logic       inv;
    case (c)
      3'd0:    begin mask = 3'b000; inv = 1'b0; end
      3'd1:    begin mask = 3'b001; inv = 1'b0; end
      3'd2:    begin mask = 3'b001; inv = 1'b1; end
      3'd3:    begin mask = 3'b100; inv = 1'b0; end
      3'd4:    begin mask = 3'b011; inv = 1'b0; end
      3'd5:    begin mask = 3'b010; inv = 1'b0; end
      3'd6:    begin mask = 3'b101; inv = 1'b0; end
      default: begin mask = 3'b000; inv = 1'b1; end
    endcase
    return (|(f & mask)) ^ inv;
  endfunction

  task automatic drive_flags(input bit we, input logic [2:0] f);
    bus.flag_we = we;
    {bus.a_less, bus.a_greater, bus.equal} = f;
    if (we) begin
      m_flags = f;
      if (!(f == 3'b001 || f == 3'b010 || f == 3'b100)) m_err = 1'b1;
    end
  endtask

  task automatic write_flags(input logic [2:0] f);
    @(negedge clk);
    drive_flags(1'b1, f);
    @(negedge clk);
    drive_flags(1'b0, 3'b000);
    chk("flags_q_write", 32'(bus.flags_q), 32'(m_flags));
    chk("flag_err_write", 32'(bus.flag_err), 32'(m_err));
  endtask

  task automatic run_branch(input logic [2:0] cond, input logic [15:0] pc, input logic [15:0] tgt,
                            input bit acc_we, input logic [2:0] acc_f,
                            input int eval_we, input logic [2:0] eval_f, input int hold_wait,
                            output logic got_t, output logic [15:0] got_nx);
    int guard;
    int lat;
    logic exp_t;
    logic [15:0] exp_nx;
    @(negedge clk);
    bus.br_valid  = 1'b1;
    bus.br_cond   = cond;
    bus.br_pc     = pc;
    bus.br_target = tgt;
    drive_flags(acc_we, acc_f);
    guard = 0;
    while (bus.br_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("accept_timeout", 32'(bus.br_ready), 32'd1);
    @(negedge clk);
    bus.br_valid  = 1'b0;
    bus.res_ready = 1'b1;   // ignored while no result is valid
    drive_flags(1'b0, 3'b000);
    lat = 1;
    for (int i = 0; i < eval_we; i++) begin
      drive_flags(1'b1, eval_f);
      chk("eval_res_valid", 32'(bus.res_valid), 32'd0);
      chk("eval_br_ready", 32'(bus.br_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    drive_flags(1'b0, 3'b000);
    guard = 0;
    while (bus.res_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      lat++;
      guard++;
    end
    bus.res_ready = 1'b0;
    chk("latency", 32'(lat), 32'(2 + eval_we));
    exp_t  = model_taken(m_flags, cond);
    exp_nx = exp_t ? tgt : pc + 16'd1;
    got_t  = bus.res_taken;
    got_nx = bus.res_next_pc;
    chk("res_valid", 32'(bus.res_valid), 32'd1);
    chk("res_taken", 32'(got_t), 32'(exp_t));
    chk("res_next_pc", 32'(got_nx), 32'(exp_nx));
    for (int i = 0; i < hold_wait; i++) begin
      bus.br_valid = 1'b1;  // must be ignored outside IDLE
      bus.br_cond  = 3'b111;
      @(negedge clk);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_taken", 32'(bus.res_taken), 32'(exp_t));
      chk("hold_next_pc", 32'(bus.res_next_pc), 32'(exp_nx));
      chk("hold_br_ready", 32'(bus.br_ready), 32'd0);
    end
    bus.br_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("release_valid", 32'(bus.res_valid), 32'd0);
    chk("idle_br_ready", 32'(bus.br_ready), 32'd1);
    chk("flags_q", 32'(bus.flags_q), 32'(m_flags));
    chk("flag_err", 32'(bus.flag_err), 32'(m_err));
    $display("branch cond=%0d pc=%h tgt=%h flags=%b lat=%0d taken=%0b next=%h",
             cond, pc, tgt, m_flags, lat, got_t, got_nx);
  endtask

  initial begin
    logic        t;
    logic [15:0] nx;
    logic [2:0]  rc;
    logic [2:0]  rf;

    //          wr   wf      cond   pc        tgt       hold taken next
    vecs[0] = '{1'b0, 3'b000, 3'd1, 16'h0010, 16'h0100, 0, 1'b1, 16'h0100};
    vecs[1] = '{1'b1, 3'b100, 3'd3, 16'h0020, 16'h0040, 0, 1'b1, 16'h0040};
    vecs[2] = '{1'b0, 3'b000, 3'd4, 16'h0020, 16'h0040, 1, 1'b0, 16'h0021};
    vecs[3] = '{1'b0, 3'b000, 3'd6, 16'h0020, 16'h0040, 0, 1'b1, 16'h0040};
    vecs[4] = '{1'b0, 3'b000, 3'd5, 16'h0020, 16'h0040, 2, 1'b0, 16'h0021};
    vecs[5] = '{1'b1, 3'b001, 3'd2, 16'hFFFF, 16'h1234, 5, 1'b0, 16'h0000};

    rst = 1'b1;
    bus.flag_we = 1'b0; bus.a_less = 1'b0; bus.a_greater = 1'b0; bus.equal = 1'b0;
    bus.br_valid = 1'b0; bus.br_cond = 3'd0; bus.br_pc = '0; bus.br_target = '0;
    bus.res_ready = 1'b0;
    m_flags = 3'b001;
    m_err   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_br_ready", 32'(bus.br_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_taken", 32'(bus.res_taken), 32'd0);
    chk("rst_next_pc", 32'(bus.res_next_pc), 32'd0);
    chk("rst_flags_q", 32'(bus.flags_q), 32'd1);
    chk("rst_flag_err", 32'(bus.flag_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_br_ready", 32'(bus.br_ready), 32'd1);

    // table-driven vectors
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) write_flags(vecs[i].wf);
      run_branch(vecs[i].cond, vecs[i].pc, vecs[i].tgt, 1'b0, 3'b000, 0, 3'b000,
                 vecs[i].hold, t, nx);
      chk("vec_taken", 32'(t), 32'(vecs[i].exp_t));
      chk("vec_next_pc", 32'(nx), 32'(vecs[i].exp_nx));
    end

    // flag write in EVAL stalls one cycle; GT sees the new greater flag
    run_branch(3'd5, 16'h0030, 16'h0300, 1'b0, 3'b000, 1, 3'b010, 0, t, nx);
    chk("stall_gt_taken", 32'(t), 32'd1);
    chk("stall_gt_next", 32'(nx), 32'h0300);

    // flag write in the accept cycle is visible without a stall
    run_branch(3'd3, 16'h0050, 16'h0500, 1'b1, 3'b100, 0, 3'b000, 0, t, nx);
    chk("acc_we_lt_taken", 32'(t), 32'd1);

    // non-one-hot write sets sticky error; later valid write keeps it
    write_flags(3'b011);
    chk("err_set", 32'(bus.flag_err), 32'd1);
    chk("err_flags_latched", 32'(bus.flags_q), 32'b011);
    write_flags(3'b100);
    chk("err_sticky", 32'(bus.flag_err), 32'd1);
    run_branch(3'd2, 16'h0060, 16'h0600, 1'b0, 3'b000, 0, 3'b000, 0, t, nx);
    chk("ne_after_err_taken", 32'(t), 32'd1);

    // all-zero flags: NE taken, EQ not taken
    write_flags(3'b000);
    run_branch(3'd1, 16'h0070, 16'h0700, 1'b0, 3'b000, 0, 3'b000, 0, t, nx);
    chk("zero_flags_eq", 32'(t), 32'd0);
    run_branch(3'd2, 16'h0070, 16'h0700, 1'b0, 3'b000, 0, 3'b000, 0, t, nx);
    chk("zero_flags_ne", 32'(t), 32'd1);

    // asynchronous reset while in HOLD
    write_flags(3'b010);
    @(negedge clk);
    bus.br_valid = 1'b1; bus.br_cond = 3'd7; bus.br_pc = 16'h0080; bus.br_target = 16'h0800;
    @(negedge clk);
    bus.br_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_hold_valid", 32'(bus.res_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_res_valid", 32'(bus.res_valid), 32'd0);
    chk("async_flags_q", 32'(bus.flags_q), 32'd1);
    chk("async_flag_err", 32'(bus.flag_err), 32'd0);
    chk("async_br_ready", 32'(bus.br_ready), 32'd0);
    chk("async_next_pc", 32'(bus.res_next_pc), 32'd0);
    m_flags = 3'b001;
    m_err   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_br_ready", 32'(bus.br_ready), 32'd1);
    run_branch(3'd1, 16'h0090, 16'h0900, 1'b0, 3'b000, 0, 3'b000, 0, t, nx);
    chk("after_rst_eq_taken", 32'(t), 32'd1);

    // randomized branches against the reference model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        rf = 3'($urandom_range(0, 7));
        write_flags(rf);
      end
      rc = 3'($urandom_range(0, 7));
      rf = 3'($urandom_range(0, 7));
      run_branch(rc, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 rf, $urandom_range(0, 2), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3), t, nx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
- Consumer end of the 16-bit magnitude comparator's flag interface (a_less, a_greater, equal).
- Latches the comparator flags into a status register on command.
- Accepts branch requests over a valid/ready handshake and resolves taken/not-taken against the latched flags.
- Returns the next PC over a second valid/ready handshake; sits between the comparator/ALU and the CPU fetch stage.

Parameters:
- ADDR_W, 16, width of PC and branch target.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- flag_we  input  1  latch comparator flags this cycle
- a_less  input  1  comparator flag: inp1 < inp2
- a_greater  input  1  comparator flag: inp1 > inp2
- equal  input  1  comparator flag: inp1 == inp2
- br_valid  input  1  branch request valid
- br_ready  output  1  unit can accept a request
- br_cond  input  3  condition code (see Behaviour)
- br_pc  input  ADDR_W  PC of the branch instruction
- br_target  input  ADDR_W  branch target address
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- res_taken  output  1  branch taken
- res_next_pc  output  ADDR_W  resolved next PC
- flags_q  output  3  latched flags {less, greater, equal}
- flag_err  output  1  sticky error: latched flags were not one-hot

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, flags_q=3'b001 (equal), flag_err=0.
  - br_ready=0 while rst is high, 1 after release; res_valid=0, res_taken=0, res_next_pc=0.
  - Any captured request is discarded.
- Flag register:
  - On flag_we, flags_q <= {a_less, a_greater, equal} at the next edge. Flag writes are independent of the FSM state.
  - If the written value is not one-hot, flag_err <= 1. flag_err clears only on reset; the value is still latched.
- Condition codes:
  - 000 NEVER, 001 EQ, 010 NE, 011 LT, 100 GE (greater|equal), 101 GT, 110 LE (less|equal), 111 ALWAYS.
- FSM:
  - IDLE: br_ready=1. On br_valid&br_ready, capture br_cond, br_pc and br_target, then go to EVAL.
  - EVAL: br_ready=0.
    - If flag_we=1 this cycle (flags in flight), stay in EVAL.
    - Else compute taken from flags_q and the captured cond. Register res_taken and res_next_pc = taken ? target : (pc+1) mod 2^ADDR_W. Set res_valid=1 and go to HOLD.
  - HOLD: br_ready=0; res_valid, res_taken and res_next_pc are held stable.
    - On res_ready, res_valid <= 0 and go to IDLE.
- Latency and throughput:
  - Minimum latency is 2 edges from accept to res_valid, +1 per EVAL-cycle flag_we.
  - A flag_we in the accept cycle is visible to that branch, with no stall.
  - Peak throughput is one branch per 3 cycles; no overlap.
- Boundary conditions:
  - pc=2^ADDR_W-1, not taken → next_pc=0.
  - br_valid asserted in EVAL/HOLD is ignored; the requester must hold it until accepted.
  - res_ready while res_valid=0 is ignored.
  - Non-one-hot flags are evaluated bitwise as latched (e.g. 3'b000: EQ, LT and GT are not taken; NE is taken).

Decomposition:
- Package cpu_cond_pkg:
  - cond_e enum (3-bit codes above).
  - flags_t packed struct {less, greater, equal}.
  - FLAGS_RESET = 3'b001.
  - state_e enum {IDLE, EVAL, HOLD}.
- One combinational sub-module cond_eval (flags_t, cond_e → taken), reusable by other control logic; FSM and registers stay in cond_branch_unit.

Test Plan:
- Reset then branch EQ, pc=16'h0010, target=16'h0100, no flag_we → res_taken=1, res_next_pc=16'h0100, res_valid two edges after accept.
- flag_we with less=1, then LT/GE/LE/GT branches, pc=16'h0020, target=16'h0040 → taken 1/0/1/0; next_pc 0040/0021/0040/0021.
- Branch accepted with flag_we (greater=1) in the EVAL cycle, cond GT → EVAL extended one cycle, res_taken=1 using the new flags.
- NE, not taken (flags=equal), pc=16'hFFFF → res_next_pc=16'h0000. Then hold res_ready=0 for 5 cycles → outputs stable, br_ready=0 throughout.
- flag_we with flags 3'b011 → flag_err=1 and remains 1 after later valid writes; cond NE → taken.
- Assert rst while in HOLD → res_valid=0, flags_q=3'b001, flag_err=0 immediately (async); after release br_ready=1 and the next request completes normally.
